// File: rtl/decoder2to4_seq.sv
// decoder2to4_seq: buffers binary codes in a small FIFO and replays each as a one-hot word held for HOLD cycles.
// Latency: code accepted at edge k into an empty, idle block drives y at edge k+1; y returns to 0 at k+1+HOLD.
// Backpressure: in_ready low when the FIFO is full or clr is high; a pop in the same cycle does not free a slot early.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   clr             synchronous flush: empties the FIFO and returns the sequencer to IDLE
//   in_valid/ready  input handshake; transfer on a rising edge with both high
//   in_code, in_en  code to decode; in_en=0 queues an idle symbol (y all-zero but still held)
//   y, y_valid      registered decoded word and its hold-window qualifier
//   busy            sequencer holding a symbol or FIFO non-empty
//   count           FIFO occupancy

// decoder2to4_seq_fifo: generic FIFO with registered occupancy and a head-of-queue read port.
// Latency: a pushed entry is visible at head_dat_o one edge after the push when the FIFO was empty.
// Backpressure: push ignored when full, pop ignored when empty; flush_i overrides both.
module decoder2to4_seq_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // DEPTH is a power of two, so the pointers wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only read while count_q says the slot is live.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// decoder2to4_seq: FIFO-buffered binary-to-one-hot decoder with programmable hold time.
// Latency: one edge from acceptance (into an empty, idle block) to y; each symbol held exactly HOLD cycles, back-to-back.
// Backpressure: in_ready = FIFO not full and no clr, from registered occupancy only.
module decoder2to4_seq #(
  parameter int IN_W  = 2,
  parameter int HOLD  = 4,
  parameter int DEPTH = 4,
  localparam int OUT_W = 2 ** IN_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             busy,
  output logic [CW-1:0]    count
);

  if (IN_W < 1 || IN_W > 4) begin : g_bad_in_w
    $error("decoder2to4_seq: IN_W must be in 1..4");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("decoder2to4_seq: HOLD must be in 1..255");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decoder2to4_seq: DEPTH must be a power of two in 2..16");
  end

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e           state_q;
  logic [7:0]       hcnt_q;
  logic [OUT_W-1:0] y_q;
  logic             y_valid_q;

  logic [IN_W:0]    head_dat;     // {en, code} at the FIFO head
  logic [CW-1:0]    fifo_count;
  logic             fifo_nempty;
  logic             slot_free;
  logic             push;
  logic             pop;

  function automatic logic [OUT_W-1:0] decode(input logic [IN_W:0] sym);
    logic [OUT_W-1:0] word;
    word = '0;
    if (sym[IN_W]) begin
      word[sym[IN_W-1:0]] = 1'b1;
    end
    return word;
  endfunction

  assign fifo_nempty = (fifo_count != '0);

  // The output slot frees up in IDLE, or on the last cycle of a hold window;
  // popping then gives back-to-back symbols with no gap cycle.
  assign slot_free = (state_q == S_IDLE) || (hcnt_q == 8'd0);
  assign pop       = fifo_nempty && slot_free && !clr;

  // No pass-through: ready depends on registered occupancy, not on this cycle's pop.
  assign in_ready = (fifo_count < CW'(DEPTH)) && !clr;
  assign push     = in_valid && in_ready;

  decoder2to4_seq_fifo #(
    .W     (IN_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (clr),
    .push_i     (push),
    .push_dat_i ({in_en, in_code}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (clr) begin
      state_q   <= S_IDLE;
      hcnt_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            y_q       <= decode(head_dat);
            y_valid_q <= 1'b1;
            hcnt_q    <= HOLD_M1;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hcnt_q != 8'd0) begin
            hcnt_q <= hcnt_q - 8'd1;
          end else if (pop) begin
            y_q       <= decode(head_dat);
            y_valid_q <= 1'b1;
            hcnt_q    <= HOLD_M1;
          end else begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          y_q       <= '0;
          y_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q == S_HOLD) || fifo_nempty;
  assign count   = fifo_count;

endmodule
